// File: rtl/trace_pkg.sv
// Shared event types and constants for the commit-trace recorder.
package trace_pkg;

  localparam int DROP_CNT_W    = 16;
  // Per-entry stamp field width; trace_capture's STAMP_W is expected to match.
  localparam int TRACE_STAMP_W = 16;

  typedef enum logic [1:0] {
    REG_WR = 2'd0,
    MEM_WR = 2'd1,
    MEM_RD = 2'd2
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e              kind;
    logic [8:0]               addr;
    logic [31:0]              data;
    logic [8:0]               pc;
    logic [TRACE_STAMP_W-1:0] stamp;
  } trace_event_t;

endpackage

// File: rtl/trace_fifo.sv
// Dual-push/single-pop event FIFO; head is registered storage, one cycle push-to-head.
// No internal backpressure: the caller only pushes into free slots and pops when count != 0.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push0,
  input  trace_event_t            din0,
  input  logic                    push1,
  input  trace_event_t            din1,
  input  logic                    pop,
  output logic [$clog2(DEPTH):0]  count,
  output trace_event_t            head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  trace_event_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr_1;

  assign wr_ptr_1 = wr_ptr + AW'(1);

  // push1 always lands in the slot after push0, so the two writes never collide.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr]   <= din0;
    if (push1) mem[wr_ptr_1] <= din1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/trace_capture.sv
// Samples core reg/mem commit events into a timestamped FIFO, visible one cycle after capture.
// Downstream valid/ready stall holds the head; when slots run out, events drop and are counted.
module trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [8:0]            tb_PC,
  input  logic                  tb_reg_write,
  input  logic [4:0]            tb_reg_addr,
  input  logic [31:0]           tb_reg_write_data,
  input  logic                  tb_mem_write,
  input  logic                  tb_mem_read,
  input  logic [8:0]            tb_mem_addr,
  input  logic [31:0]           tb_mem_write_data,
  input  logic [31:0]           tb_mem_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_kind,
  output logic [8:0]            out_addr,
  output logic [31:0]           out_data,
  output logic [8:0]            out_pc,
  output logic [STAMP_W-1:0]    out_stamp,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [STAMP_W-1:0]  stamp;
  logic [CW-1:0]       count;
  logic [CW-1:0]       free;
  trace_event_t        reg_ev;
  trace_event_t        mem_ev;
  trace_event_t        din0;
  trace_event_t        head;
  logic                reg_hit;
  logic                mem_wr_hit;
  logic                mem_rd_hit;
  logic                mem_hit;
  logic                pop;
  logic                push0;
  logic                push1;
  logic [1:0]          n_ev;
  logic [1:0]          n_push;
  logic [1:0]          n_drop;
  logic [DROP_CNT_W:0] drop_sum;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A slot freed by this cycle's pop is reusable by this cycle's push.
  assign free      = CW'(DEPTH) - count + CW'(pop);

  always_comb begin
    reg_hit    = en & tb_reg_write;
    mem_wr_hit = en & tb_mem_write & ~tb_mem_read;
    mem_rd_hit = en & tb_mem_read & ~tb_mem_write;
    mem_hit    = mem_wr_hit | mem_rd_hit;

    reg_ev.kind  = REG_WR;
    reg_ev.addr  = {4'd0, tb_reg_addr};
    reg_ev.data  = tb_reg_write_data;
    reg_ev.pc    = tb_PC;
    reg_ev.stamp = TRACE_STAMP_W'(stamp);

    mem_ev.kind  = mem_wr_hit ? MEM_WR : MEM_RD;
    mem_ev.addr  = tb_mem_addr;
    mem_ev.data  = mem_wr_hit ? tb_mem_write_data : tb_mem_read_data;
    mem_ev.pc    = tb_PC;
    mem_ev.stamp = TRACE_STAMP_W'(stamp);

    // REG goes first, so with a single free slot it is the MEM event that drops.
    n_ev     = {1'b0, reg_hit} + {1'b0, mem_hit};
    push0    = (n_ev != 2'd0) && (free != '0);
    push1    = (n_ev == 2'd2) && (free > CW'(1));
    din0     = reg_hit ? reg_ev : mem_ev;
    n_push   = {1'b0, push0} + {1'b0, push1};
    n_drop   = n_ev - n_push;
    drop_sum = {1'b0, drop_cnt} + (DROP_CNT_W+1)'(n_drop);
  end

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push0 (push0),
    .din0  (din0),
    .push1 (push1),
    .din1  (mem_ev),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stamp    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      stamp <= stamp + STAMP_W'(1);
      if (n_drop != 2'd0) begin
        overflow <= 1'b1;
        drop_cnt <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
      end
    end
  end

  // Storage is not reset, so the data outputs are forced to zero whenever the FIFO is empty.
  assign out_kind  = out_valid ? head.kind : 2'd0;
  assign out_addr  = out_valid ? head.addr : 9'd0;
  assign out_data  = out_valid ? head.data : 32'd0;
  assign out_pc    = out_valid ? head.pc   : 9'd0;
  assign out_stamp = out_valid ? STAMP_W'(head.stamp) : '0;

endmodule
